uart_rx_controller: RTL and testbench

Sequencing and buffering controller for the Hamming(7,4) UART receiver. It generates the receiver's oversample tick (the receiver's `ena`) and edge-detects the receiver's codeword-valid output. Each 7-bit codeword is Hamming-decoded and corrected to a nibble. Nibble pairs are assembled into bytes and delivered through a small show-ahead FIFO with a valid/ready handshake. Sits between the receiver and the byte consumer; owns error counting, inter-nibble timeout and overflow reporting.

---
 rtl/uart_rx_controller.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// Hamming(7,4) UART receive controller: oversample tick, codeword accept and decode,
// nibble pairing with timeout, show-ahead byte FIFO. Define HAMMING_CORRECT_EN to correct single-bit errors.
module uart_rx_controller #(
  parameter int CLK_DIV       = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  output logic       rx_ena,
  input  logic [6:0] rx_data,
  input  logic       rx_valid,
  input  logic [1:0] rx_state,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       corrected,
  output logic       frame_drop,
  output logic       overflow,
  output logic [7:0] err_count
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = 16;
  localparam logic [1:0]    RX_IDLE  = 2'b00;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {WAIT_LO, HAVE_LO} pair_t;
  typedef struct packed {
    logic [3:0] nib;
    logic       err;
  } dec_t;

  // ---------------- oversample tick ----------------
  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                              div_cnt <= '0;
    else if (!enable || div_cnt == DIV_LAST) div_cnt <= '0;
    else                                     div_cnt <= div_cnt + 1'b1;

  assign rx_ena = enable && (div_cnt == DIV_LAST);

  // ---------------- accept edge + decode ----------------
  logic       rx_valid_q;
  logic       accept;
  logic [2:0] syn;
  logic [6:0] fix;
  dec_t       dec;
  logic       cw_ok;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_valid_q <= 1'b0;
    else        rx_valid_q <= rx_valid;

  assign accept = rx_valid && !rx_valid_q;

  always_comb begin
    syn[0]  = rx_data[0] ^ rx_data[2] ^ rx_data[4] ^ rx_data[6];
    syn[1]  = rx_data[1] ^ rx_data[2] ^ rx_data[5] ^ rx_data[6];
    syn[2]  = rx_data[3] ^ rx_data[4] ^ rx_data[5] ^ rx_data[6];
    fix     = rx_data ^ ((syn != 3'd0) ? (7'd1 << (syn - 3'd1)) : 7'd0);
    dec.nib = {fix[6], fix[5], fix[4], fix[2]};
    dec.err = |syn;
  end

`ifdef HAMMING_CORRECT_EN
  assign cw_ok = 1'b1;
`else
  // without correction a bad codeword is only counted, never paired
  assign cw_ok = !dec.err;
`endif

  // ---------------- nibble pairing ----------------
  pair_t         state, state_nx;
  logic [3:0]    lo_nib;
  logic [TW-1:0] to_cnt;
  logic          tick_idle, expire, push, drop;

  assign tick_idle = rx_ena && (rx_state == RX_IDLE);
  assign expire    = (state == HAVE_LO) && tick_idle && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WAIT_LO;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    drop     = 1'b0;
    if (!enable) begin
      state_nx = WAIT_LO;
    end else begin
      case (state)
        WAIT_LO: if (accept && cw_ok) state_nx = HAVE_LO;
        HAVE_LO: begin
          // an accept in the expiry cycle takes precedence over the drop
          if (accept) begin
            push     = cw_ok;
            state_nx = WAIT_LO;
          end else if (expire) begin
            drop     = 1'b1;
            state_nx = WAIT_LO;
          end
        end
        default: state_nx = WAIT_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lo_nib     <= '0;
      to_cnt     <= '0;
      corrected  <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      corrected  <= accept && dec.err;
      frame_drop <= drop;
      if (state == WAIT_LO && accept) lo_nib <= dec.nib;
      if (state_nx != HAVE_LO || state == WAIT_LO) to_cnt <= '0;
      else if (tick_idle)                          to_cnt <= to_cnt + 1'b1;
    end

  // ---------------- byte FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr;

  assign full       = (count == FULL_CNT);
  assign byte_valid = (count != '0);
  assign pop        = byte_valid && byte_ready;
  // a pop frees the head slot, so a push into a full FIFO still lands
  assign wr         = push && (!full || pop);
  assign byte_data  = byte_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {dec.nib, lo_nib};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end

  // ---------------- status ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push && full && !pop)                     overflow  <= 1'b1;
      if (accept && dec.err && err_count != 8'hFF)  err_count <= err_count + 8'd1;
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomized self-checking bench for uart_rx_controller against a queue-based
// behavioural model of decode, pairing, FIFO and status counters.
module tb_uart_rx_controller;
  localparam int CLK_DIV = 16, FIFO_DEPTH = 4, TIMEOUT_TICKS = 4;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear = 1'b0;
  logic       rx_valid = 1'b0, byte_ready = 1'b0;
  logic [6:0] rx_data = 7'd0;
  logic [1:0] rx_state = 2'd0;
  logic       rx_ena, byte_valid, corrected, frame_drop, overflow;
  logic [7:0] byte_data, err_count;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  uart_rx_controller #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .rx_ena(rx_ena),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_state(rx_state),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .corrected(corrected), .frame_drop(frame_drop), .overflow(overflow), .err_count(err_count)
  );

  // monitor: popped bytes and pulse counts, sampled mid-cycle
  logic [7:0] got_mem [0:1023];
  int n_got = 0, n_corr = 0, n_drop = 0;
  always @(negedge clk) if (rst_n) begin
    if (byte_valid && byte_ready && n_got < 1024) begin got_mem[n_got] = byte_data; n_got++; end
    if (corrected)  n_corr++;
    if (frame_drop) n_drop++;
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  int         got_rd = 0, m_err = 0, m_bad = 0;
  bit         m_ovf = 0, m_have = 0, m_hold = 0;
  logic [3:0] m_lo;

  // syndrome = XOR of the 1-based positions of all set bits
  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 7; i++) if (cw[i]) s ^= 3'(i + 1);
    return s;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] n);
    logic [6:0] cw;
    logic [2:0] s;
    cw = 7'd0;
    cw[2] = n[0]; cw[4] = n[1]; cw[5] = n[2]; cw[6] = n[3];
    s = syndrome(cw);
    cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
    return cw;
  endfunction

  task automatic model_accept(input logic [6:0] cw);
    logic [2:0] s;
    logic [6:0] c;
    logic [3:0] nib;
    s = syndrome(cw);
    c = cw;
    if (s != 0) begin
      m_bad++;
      if (m_err < 255) m_err++;
`ifndef HAMMING_CORRECT_EN
      m_have = 0;
      return;
`endif
      c[s - 1] = ~c[s - 1];
    end
    nib = {c[6], c[5], c[4], c[2]};
    if (!m_have) begin m_have = 1; m_lo = nib; end
    else begin
      m_have = 0;
      if (m_hold && exp_q.size() >= FIFO_DEPTH) m_ovf = 1;
      else exp_q.push_back({nib, m_lo});
    end
  endtask

  task automatic send_cw(input logic [6:0] cw, input int hi);
    model_accept(cw);
    rx_state = 2'b01; rx_data = cw; rx_valid = 1'b1;
    repeat (hi) @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rx_state = 2'b00;
  endtask

  // idle long enough for any stored low nibble to time out
  task automatic settle();
    repeat (100) @(posedge clk); #1;
    m_have = 0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rx_ena !== 1'b0) begin failures++; $display("FAIL reset_rx_ena: got %0b expected 0", rx_ena); end
    checks++; if (byte_valid !== 1'b0 || byte_data !== 8'h00) begin failures++; $display("FAIL reset_fifo: got v=%0b d=%0h expected 0/00", byte_valid, byte_data); end
    checks++; if ({corrected, frame_drop, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %0b expected 000", {corrected, frame_drop, overflow}); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_tick();
    int first = 0, second = 0, cnt = 0;
    repeat (5) @(posedge clk); #1;
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rx_ena) begin if (first == 0) first = k; else if (second == 0) second = k; end
    end
    checks++; if (first != CLK_DIV) begin failures++; $display("FAIL tick_first: got cycle %0d expected %0d", first, CLK_DIV); end
    checks++; if (second != 2 * CLK_DIV) begin failures++; $display("FAIL tick_period: got cycle %0d expected %0d", second, 2 * CLK_DIV); end
    repeat (8) @(posedge clk); #1;   // now in cycle 48, a tick cycle
    checks++; if (rx_ena !== 1'b1) begin failures++; $display("FAIL tick_third: got %0b expected 1", rx_ena); end
    enable = 1'b0; #1;
    checks++; if (rx_ena !== 1'b0) begin failures++; $display("FAIL tick_stop: got %0b expected 0", rx_ena); end
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (rx_ena) cnt++; end
    checks++; if (cnt != 0) begin failures++; $display("FAIL tick_disabled: got %0d pulses expected 0", cnt); end
    @(posedge clk); #1; enable = 1'b1;
  endtask

  task automatic test_basic();
    int c0;
    settle(); byte_ready = 1'b1; c0 = n_corr;
    send_cw(7'h2D, 16); send_cw(7'h52, 16); drain();
    checks++; if (n_got - got_rd != 1 || got_mem[got_rd] !== 8'hA5) begin failures++; $display("FAIL basic_byte: got %0d bytes first %0h expected 1 byte a5", n_got - got_rd, got_mem[got_rd]); end
    checks++; if (exp_q.size() != 1 || exp_q[0] !== 8'hA5) begin failures++; $display("FAIL basic_model: got %0d entries expected 1", exp_q.size()); end
    checks++; if (n_corr != c0) begin failures++; $display("FAIL basic_corrected: got %0d pulses expected 0", n_corr - c0); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL basic_err: got %0d expected 0", err_count); end
    got_rd = n_got; exp_q.delete();
  endtask

  task automatic test_correct();
    int c0;
    settle(); c0 = n_corr;
    send_cw(7'h3D, 16); send_cw(7'h52, 16); drain();
    checks++; if (n_got - got_rd != exp_q.size()) begin failures++; $display("FAIL correct_count: got %0d bytes expected %0d", n_got - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < n_got; i++) begin
      checks++; if (got_mem[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL correct_byte: got %0h expected %0h", got_mem[got_rd + i], exp_q[i]); end
    end
    checks++; if (n_corr - c0 != 1) begin failures++; $display("FAIL correct_pulse: got %0d pulses expected 1", n_corr - c0); end
    checks++; if (err_count !== 8'(m_err)) begin failures++; $display("FAIL correct_err: got %0d expected %0d", err_count, m_err); end
    got_rd = n_got; exp_q.delete();
  endtask

  task automatic test_timeout();
    int ticks = 0, d0;
    bit seen = 0;
    settle();
    send_cw(7'h2D, 16);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (frame_drop) seen = 1; else if (rx_ena) ticks++;
    end
    checks++; if (!seen || ticks != TIMEOUT_TICKS) begin failures++; $display("FAIL timeout_ticks: got seen=%0b ticks=%0d expected 1/%0d", seen, ticks, TIMEOUT_TICKS); end
    @(posedge clk); #1; m_have = 0;
    send_cw(7'h52, 16); send_cw(7'h2D, 16);
    // counter must hold while the receiver is busy
    send_cw(7'h2D, 16); d0 = n_drop;
    rx_state = 2'b01; repeat (120) @(posedge clk); #1;
    send_cw(7'h52, 16); drain();
    checks++; if (n_drop != d0) begin failures++; $display("FAIL timeout_hold: got %0d drops expected 0", n_drop - d0); end
    checks++; if (n_got - got_rd != exp_q.size()) begin failures++; $display("FAIL timeout_count: got %0d bytes expected %0d", n_got - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < n_got; i++) begin
      checks++; if (got_mem[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL timeout_byte%0d: got %0h expected %0h", i, got_mem[got_rd + i], exp_q[i]); end
    end
    got_rd = n_got; exp_q.delete();
  endtask

  task automatic test_random();
    int c0, b0;
    logic [6:0] cw;
    settle(); c0 = n_corr; b0 = m_bad;
    for (int p = 0; p < 60; p++) begin
      cw = encode(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) cw[$urandom_range(0, 6)] ^= 1'b1;
      send_cw(cw, $urandom_range(2, 20));
    end
    drain();
    checks++; if (n_got - got_rd != exp_q.size()) begin failures++; $display("FAIL random_count: got %0d bytes expected %0d", n_got - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < n_got; i++) begin
      checks++; if (got_mem[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL random_byte%0d: got %0h expected %0h", i, got_mem[got_rd + i], exp_q[i]); end
    end
    checks++; if (n_corr - c0 != m_bad - b0) begin failures++; $display("FAIL random_pulses: got %0d expected %0d", n_corr - c0, m_bad - b0); end
    checks++; if (err_count !== 8'(m_err)) begin failures++; $display("FAIL random_err: got %0d expected %0d", err_count, m_err); end
    got_rd = n_got; exp_q.delete();
  endtask

  task automatic test_overflow();
    settle(); byte_ready = 1'b0; m_hold = 1; m_ovf = 0;
    for (int p = 0; p < 5; p++) begin
      send_cw(encode(4'($urandom_range(0, 15))), 16);
      send_cw(encode(4'($urandom_range(0, 15))), 16);
    end
    checks++; if (byte_valid !== 1'b1 || byte_data !== exp_q[0]) begin failures++; $display("FAIL ovf_head: got v=%0b d=%0h expected 1/%0h", byte_valid, byte_data, exp_q[0]); end
    checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL ovf_flag: got %0b expected %0b", overflow, m_ovf); end
    byte_ready = 1'b1; m_hold = 0; drain();
    checks++; if (n_got - got_rd != FIFO_DEPTH) begin failures++; $display("FAIL ovf_count: got %0d bytes expected %0d", n_got - got_rd, FIFO_DEPTH); end
    for (int i = 0; i < exp_q.size() && got_rd + i < n_got; i++) begin
      checks++; if (got_mem[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d: got %0h expected %0h", i, got_mem[got_rd + i], exp_q[i]); end
    end
    got_rd = n_got; exp_q.delete();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0; m_ovf = 0; m_err = 0;
    checks++; if (overflow !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL ovf_clear: got ovf=%0b err=%0d expected 0/0", overflow, err_count); end
  endtask

  task automatic test_err_saturate();
    settle(); rx_state = 2'b01;
    for (int i = 0; i < 260; i++) begin
      model_accept(7'h3D);
      rx_data = 7'h3D; rx_valid = 1'b1; @(posedge clk); #1;
      rx_valid = 1'b0; @(posedge clk); #1;
    end
    rx_state = 2'b00; drain();
    checks++; if (err_count !== 8'd255 || m_err != 255) begin failures++; $display("FAIL err_saturate: got %0d expected 255", err_count); end
    checks++; if (n_got - got_rd != exp_q.size()) begin failures++; $display("FAIL err_bytes: got %0d bytes expected %0d", n_got - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < n_got; i++) begin
      checks++; if (got_mem[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL err_byte%0d: got %0h expected %0h", i, got_mem[got_rd + i], exp_q[i]); end
    end
    got_rd = n_got; exp_q.delete();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0; m_err = 0;
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL err_clear: got %0d expected 0", err_count); end
    // clear beats a simultaneous increment
    model_accept(7'h3D); m_err = 0;
    rx_data = 7'h3D; rx_valid = 1'b1; clear = 1'b1; @(posedge clk); #1;
    clear = 1'b0; rx_valid = 1'b0; @(posedge clk); #1;
    checks++; if (err_count !== 8'(m_err)) begin failures++; $display("FAIL err_clear_prio: got %0d expected %0d", err_count, m_err); end
  endtask

  task automatic test_hold_reset();
    settle();
    send_cw(7'h2D, 40); send_cw(7'h52, 16); drain();
    checks++; if (n_got - got_rd != 1 || got_mem[got_rd] !== 8'hA5) begin failures++; $display("FAIL long_valid: got %0d bytes first %0h expected 1 byte a5", n_got - got_rd, got_mem[got_rd]); end
    got_rd = n_got; exp_q.delete();
    byte_ready = 1'b0;
    send_cw(7'h2D, 16); send_cw(7'h52, 16); send_cw(7'h2D, 16);
    rst_n = 1'b0; #1;
    checks++; if ({byte_valid, rx_ena, corrected, frame_drop, overflow} !== 5'b0 || byte_data !== 8'h00 || err_count !== 8'h00) begin
      failures++; $display("FAIL async_reset: got v=%0b d=%0h err=%0d expected all 0", byte_valid, byte_data, err_count); end
    @(posedge clk); #1; rst_n = 1'b1;
    exp_q.delete(); m_have = 0; m_err = 0; m_ovf = 0; got_rd = n_got;
    byte_ready = 1'b1;
    send_cw(7'h52, 16); send_cw(7'h2D, 16); drain();
    checks++; if (n_got - got_rd != 1 || got_mem[got_rd] !== 8'h5A) begin failures++; $display("FAIL post_reset: got %0d bytes first %0h expected 1 byte 5a", n_got - got_rd, got_mem[got_rd]); end
    got_rd = n_got; exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_tick();
    test_basic();
    test_correct();
    test_timeout();
    test_random();
    test_overflow();
    test_err_saturate();
    test_hold_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
